// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of a PWM input in timebase ticks
module pwm_capture #(
  parameter int WIDTH = 16
) (
  input  logic             sysclk,
  input  logic             sysreset,
  input  logic             counter_event,
  input  logic             pwm_in,
  input  logic             ack,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             ready,
  output logic             missed,
  output logic             overflow,
  output logic             level
);
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [1:0] WAIT_LOW = 2'd0, WAIT_RISE = 2'd1, RUN = 2'd2, STALL = 2'd3;
  logic sync1, sync2, d, counter_event_last, rise, fall, tick, cap;
  logic [1:0] state;
  logic [WIDTH-1:0] per_cnt, hi_cnt, hi_hold, tick_w;
  assign level = sync2;
  assign rise = sync2 & ~d;
  assign fall = ~sync2 & d;
  assign tick = counter_event & ~counter_event_last;
  assign tick_w = {{(WIDTH-1){1'b0}}, tick};
  assign cap = (state == RUN) && (rise || (tick && per_cnt == MAX));
  // two-flop synchronizer with edge-detect delay, plus timebase edge history
  always_ff @(posedge sysclk or posedge sysreset)
    if (sysreset) {sync1, sync2, d, counter_event_last} <= '0;
    else {sync1, sync2, d, counter_event_last} <= {pwm_in, sync1, sync2, counter_event};
  // measurement FSM: arm on a genuine rise, count ticks, capture on rise or saturation
  always_ff @(posedge sysclk or posedge sysreset)
    if (sysreset) begin
      state <= WAIT_LOW;
      per_cnt <= '0;
      hi_cnt <= '0;
      hi_hold <= '0;
      period <= '0;
      high_time <= '0;
      overflow <= 1'b0;
    end else case (state)
      WAIT_LOW: if (!level) state <= WAIT_RISE;
      WAIT_RISE, STALL: if (rise) begin
        state <= RUN;
        per_cnt <= tick_w;
        hi_cnt <= tick_w;
      end
      default: begin
        if (fall) hi_hold <= hi_cnt;
        if (rise) begin
          period <= per_cnt;
          high_time <= hi_hold;
          overflow <= 1'b0;
          per_cnt <= tick_w;
          hi_cnt <= tick_w;
        end else if (tick && per_cnt == MAX) begin
          period <= MAX;
          high_time <= (level | fall) ? hi_cnt : hi_hold;
          overflow <= 1'b1;
          state <= STALL;
        end else if (tick) begin
          per_cnt <= per_cnt + tick_w;
          if (level && hi_cnt != MAX) hi_cnt <= hi_cnt + tick_w;
        end
      end
    endcase
  // ready/missed handshake; a capture beats a simultaneous ack
  always_ff @(posedge sysclk or posedge sysreset)
    if (sysreset) begin
      ready <= 1'b0;
      missed <= 1'b0;
    end else begin
      ready <= cap | (ready & ~ack);
      missed <= cap ? (missed | (ready & ~ack)) : (missed & ~ack);
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed PWM waveforms against a cumulative-tick reference model
module tb_pwm_capture;
  logic sysclk = 1'b0;
  logic sysreset, counter_event, pwm_in;
  logic ack = 1'b0;
  logic ack_man, auto_ack;
  int ph;
  logic [15:0] per16, hi16;
  logic [7:0] per8, hi8;
  logic rdy16, mis16, ovf16, lvl16, rdy8, mis8, ovf8, lvl8;
  logic [15:0] g_per[2], g_hi[2];
  logic g_ovf[2], g_rdy[2], g_mis[2], g_lvl[2];
  int n_chk = 0, n_fail = 0;
  int lit_req = 0, lit_done = 0;
  int lk, lp, lh, lo, lr, lm;
  bit ms1[2], ms2[2], mdl[2], mcel[2];
  int mmode[2];
  longint mC[2], mH[2], mCs[2], mHs[2], mHf[2], ep[2], eh[2];
  int eo[2], er[2], em[2];
  longint maxv[2] = '{65535, 255};
  bit lv, rs, fl, tk, cap;

  always #5 sysclk = ~sysclk;

  pwm_capture #(.WIDTH(16)) dut16 (
    .sysclk(sysclk), .sysreset(sysreset), .counter_event(counter_event), .pwm_in(pwm_in), .ack(ack),
    .period(per16), .high_time(hi16), .ready(rdy16), .missed(mis16), .overflow(ovf16), .level(lvl16)
  );
  pwm_capture #(.WIDTH(8)) dut8 (
    .sysclk(sysclk), .sysreset(sysreset), .counter_event(counter_event), .pwm_in(pwm_in), .ack(ack),
    .period(per8), .high_time(hi8), .ready(rdy8), .missed(mis8), .overflow(ovf8), .level(lvl8)
  );

  assign g_per[0] = per16;
  assign g_per[1] = {8'b0, per8};
  assign g_hi[0] = hi16;
  assign g_hi[1] = {8'b0, hi8};
  assign g_ovf[0] = ovf16;
  assign g_ovf[1] = ovf8;
  assign g_rdy[0] = rdy16;
  assign g_rdy[1] = rdy8;
  assign g_mis[0] = mis16;
  assign g_mis[1] = mis8;
  assign g_lvl[0] = lvl16;
  assign g_lvl[1] = lvl8;

  // reference model: periods and high times are differences of running tick totals
  always @(posedge sysclk or posedge sysreset) begin
    for (int k = 0; k < 2; k++) begin
      if (sysreset) begin
        ms1[k] = 0; ms2[k] = 0; mdl[k] = 0; mcel[k] = 0; mmode[k] = 0;
        mC[k] = 0; mH[k] = 0; mCs[k] = 0; mHs[k] = 0; mHf[k] = 0;
        ep[k] = 0; eh[k] = 0; eo[k] = 0; er[k] = 0; em[k] = 0;
      end else begin
        lv = ms2[k];
        rs = lv && !mdl[k];
        fl = !lv && mdl[k];
        tk = counter_event && !mcel[k];
        cap = 0;
        if (mmode[k] == 2 && fl) mHf[k] = mH[k];
        if (mmode[k] == 0) begin
          if (!lv) mmode[k] = 1;
        end else if (mmode[k] != 2) begin
          if (rs) begin mmode[k] = 2; mCs[k] = mC[k]; mHs[k] = mH[k]; end
        end else if (rs) begin
          cap = 1; ep[k] = mC[k] - mCs[k]; eh[k] = mHf[k] - mHs[k]; eo[k] = 0;
          mCs[k] = mC[k]; mHs[k] = mH[k];
        end else if (tk && mC[k] - mCs[k] == maxv[k]) begin
          cap = 1; ep[k] = maxv[k]; eo[k] = 1; mmode[k] = 3;
          eh[k] = lv ? mH[k] - mHs[k] : mHf[k] - mHs[k];
        end
        mC[k] += longint'(tk);
        mH[k] += longint'(tk && lv);
        if (cap) begin
          em[k] = em[k] | int'(er[k] != 0 && !ack);
          er[k] = 1;
        end else if (ack) begin
          er[k] = 0; em[k] = 0;
        end
        mdl[k] = ms2[k]; ms2[k] = ms1[k]; ms1[k] = pwm_in; mcel[k] = counter_event;
      end
    end
  end

  task automatic chk(string nm, int k, longint got, longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d", nm, k, $time, got, exp);
    end
  endtask

  // compare every cycle against the model, plus any pending hand-computed literal check
  always @(negedge sysclk) begin
    for (int k = 0; k < 2; k++) begin
      chk("period", k, longint'(g_per[k]), ep[k]);
      chk("high_time", k, longint'(g_hi[k]), eh[k]);
      chk("overflow", k, longint'(g_ovf[k]), longint'(eo[k]));
      chk("ready", k, longint'(g_rdy[k]), longint'(er[k]));
      chk("missed", k, longint'(g_mis[k]), longint'(em[k]));
      chk("level", k, longint'(g_lvl[k]), longint'(ms2[k]));
    end
    if (lit_req != lit_done) begin
      lit_done = lit_req;
      if (lp >= 0) chk("lit_period", lk, longint'(g_per[lk]), longint'(lp));
      if (lh >= 0) chk("lit_high_time", lk, longint'(g_hi[lk]), longint'(lh));
      if (lo >= 0) chk("lit_overflow", lk, longint'(g_ovf[lk]), longint'(lo));
      if (lr >= 0) chk("lit_ready", lk, longint'(g_rdy[lk]), longint'(lr));
      if (lm >= 0) chk("lit_missed", lk, longint'(g_mis[lk]), longint'(lm));
    end
  end

  // ack driver: manual pulses, or auto-ack timed to land on the model's next capture
  always @(negedge sysclk)
    ack = ack_man | (auto_ack & (mmode[0] == 2) & ms2[0] & !mdl[0]);

  task automatic cyc();
    @(posedge sysclk);
    #2;
  endtask

  task automatic seg(int n, bit lvl);
    for (int i = 0; i < n; i++)
      for (int c = 0; c < 4; c++) begin
        counter_event = (c < 2);
        if (c == ph) pwm_in = lvl;
        cyc();
      end
  endtask

  task automatic lit(int k, int p, int h, int o, int r, int m);
    lk = k; lp = p; lh = h; lo = o; lr = r; lm = m;
    lit_req++;
    cyc();
  endtask

  task automatic ack_pulse();
    ack_man = 1;
    cyc();
    ack_man = 0;
    cyc();
  endtask

  task automatic scen1();
    seg(3, 0); seg(10, 1); seg(30, 0); seg(2, 1);
    lit(0, 40, 10, 0, 1, 0);
    lit(1, 40, 10, 0, 1, 0);
  endtask

  initial begin
    sysreset = 1; pwm_in = 0; counter_event = 0; ack_man = 0; auto_ack = 0; ph = 0;
    repeat (3) cyc();
    lit(0, 0, 0, 0, 0, 0);
    sysreset = 0;
    scen1();
    seg(8, 1); seg(15, 0);
    sysreset = 1;
    lit(0, 0, 0, 0, 0, 0);
    lit(1, 0, 0, 0, 0, 0);
    sysreset = 0;
    scen1();
    sysreset = 1; pwm_in = 1;
    repeat (3) cyc();
    sysreset = 0;
    seg(6, 1); seg(5, 0);
    repeat (2) begin seg(20, 1); seg(20, 0); end
    seg(2, 1);
    lit(0, 40, 20, 0, 1, -1);
    lit(1, 40, 20, 0, 1, -1);
    ack_pulse();
    ph = 2;
    repeat (3) begin seg(15, 1); seg(25, 0); end
    seg(2, 1);
    lit(0, 40, 15, 0, 1, -1);
    lit(1, 40, 15, 0, 1, -1);
    ph = 0;
    ack_pulse();
    seg(18, 1); seg(20, 0);
    repeat (2) begin seg(20, 1); seg(20, 0); end
    seg(2, 1);
    lit(0, 40, 20, 0, 1, 1);
    ack_pulse();
    lit(0, -1, -1, -1, 0, 0);
    auto_ack = 1;
    seg(18, 1); seg(20, 0); seg(2, 1);
    lit(0, 40, 20, 0, 1, 0);
    seg(18, 1); seg(20, 0); seg(2, 1);
    lit(0, 40, 20, 0, 1, 0);
    auto_ack = 0;
    seg(20, 0); seg(5, 1);
    ack_pulse();
    seg(300, 0);
    lit(1, 255, 5, 1, 1, 0);
    seg(20, 0);
    lit(1, 255, 5, 1, 1, 0);
    seg(4, 1); seg(8, 0); seg(4, 1); seg(8, 0); seg(2, 1);
    lit(1, 12, 4, 0, 1, -1);
    repeat (4) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Measures an incoming PWM waveform: period and high time, counted in counter_event ticks. It is the read side of the countdown PWM generator. It sits on the synapse peripheral bus next to the PWM outputs and serves tach and servo-feedback inputs, or loopback checking of our own PWM pins. Software polls ready, reads period/high_time, then pulses ack.

Parameters:
WIDTH, 16, width of tick counters and capture registers.
MAX, 2**WIDTH-1 (derived), saturation value.

Ports:
sysclk  in  1  system clock.
sysreset  in  1  asynchronous, active-high reset.
counter_event  in  1  timebase; each rising edge is one tick.
pwm_in  in  1  asynchronous PWM input, off-chip.
ack  in  1  one-cycle pulse from software; clears ready and missed.
period  out  WIDTH  last captured period, in ticks.
high_time  out  WIDTH  high time within that period, in ticks.
ready  out  1  new capture available.
missed  out  1  a capture overwrote an unacknowledged one.
overflow  out  1  last result came from counter saturation, not a real edge.
level  out  1  synchronized pwm_in.

Behaviour:
- Reset: asynchronous, active-high, on sysreset. All outputs and internal registers go to 0; FSM goes to WAIT_LOW.
- Synchronizer: 2 flops, sync1 then sync2, followed by a delay flop d.
  - level = sync2.
  - rise = sync2 & !d; fall = !sync2 & d.
  - Flop reset value is 0.
- Tick detector: registered counter_event_last; tick = counter_event & !counter_event_last. A steady-high counter_event yields one tick only.
- Counters per_cnt and hi_cnt: WIDTH bits each, saturating at MAX, never wrapping.
- FSM states and transitions:
  - WAIT_LOW: wait for level == 0, then go to WAIT_RISE. This prevents a fake rise at reset release from starting a measurement.
  - WAIT_RISE: on rise, go to RUN, set per_cnt <= tick, hi_cnt <= tick. No capture.
  - RUN, counting:
    - Each tick: per_cnt++.
    - Each tick with level == 1: hi_cnt++.
    - On fall: hi_hold <= hi_cnt. A tick in the fall cycle is not counted as high.
  - RUN, on rise (capture):
    - period <= per_cnt; high_time <= hi_hold; overflow <= 0.
    - per_cnt <= tick ? 1 : 0; hi_cnt <= tick ? 1 : 0.
    - A tick coincident with rise belongs to the new period.
  - RUN, when per_cnt == MAX and a tick arrives (capture, go to STALL):
    - period <= MAX; overflow <= 1.
    - high_time <= hi_cnt if level == 1 (input stuck high, so high_time saturates toward MAX); otherwise hi_hold.
  - STALL: ignore ticks. On rise, go to RUN with counters restarted as in WAIT_RISE, no capture.
- Capture latency: outputs update on the clock edge where rise is seen. That is 3 sysclk edges after pwm_in rises, with setup met.
- Handshake:
  - Any capture sets ready.
  - ack clears ready and missed.
  - Capture coincident with ack: ready stays 1, missed unchanged (capture wins over clear; no miss is counted).
  - Capture while ready == 1 and no ack: missed <= 1, and the capture registers are overwritten with the newest data.
- Glitches: pulses narrower than 2 sysclk may be lost in the synchronizer. No debounce; this is acceptable.
- Reset mid-measurement: all results discarded; must re-arm through WAIT_LOW.

Test Plan:
- Tick every 4 sysclk; pwm_in 10 ticks high / 30 low, repeating → from the second rise on: period=40, high_time=10, ready=1, overflow=0, missed=0. The first rise only arms the block.
- pwm_in high at reset release, then low 5 ticks, then 20/20 square → no capture from the initial high. First capture after two real rises: period=40, high_time=20.
- Tick coincident with rise, forced via alignment; 40-tick period → period=40, never 39 or 41. Next period also 40.
- Steady square wave, ack withheld across 2 captures → missed=1 and registers hold the latest values. ack pulse → ready=0, missed=0. ack in the same cycle as a capture → ready stays 1, missed=0.
- WIDTH=8, pwm_in held low after one rise → after 255 ticks: period=255, overflow=1, ready=1, high_time equals the last high phase. Further ticks: no change. Next rise restarts counting with no capture; a subsequent 12-tick period gives overflow=0, period=12.
- sysreset asserted mid-RUN → all outputs 0 the same cycle (asynchronous). After release, behaviour is identical to the first scenario.
